select_my_action: RTL and testbench



---
 rtl/select_my_action_if.sv | 24 ++
 rtl/select_my_action.sv | 109 ++++++++++
 tb/tb_select_my_action.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/select_my_action_if.sv
// Bus between the routing control and the action-selection stage:
// operand/start inputs, memory write port and result outputs.
interface select_my_action_if;
  logic        en;
  logic        start;
  logic [15:0] nexthop;
  logic [15:0] nextsinks;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] action;
  logic        forAggregation;
  logic        done;

  modport master (
    output en, start, nexthop, nextsinks,
    input  address, wr_en, mem_data_in, action, forAggregation, done
  );

  modport slave (
    input  en, start, nexthop, nextsinks,
    output address, wr_en, mem_data_in, action, forAggregation, done
  );
endinterface

// File: rtl/select_my_action.sv
// Action-selection stage: picks the transmit action from the latched next hop
// and sink, writes action and aggregation flag words to data memory.
//
// state     | meaning
// IDLE      | operands loadable, waiting for start
// COMPUTE   | action / aggregation flag latched from operands
// WR_ACTION | action word written at ACTION_ADDR
// WR_FLAG   | aggregation flag word written at FLAG_ADDR
// DONE      | done high until start drops
module select_my_action (
  input  logic                clock,
  input  logic                nrst,
  select_my_action_if.slave   bus
);

  localparam logic [15:0] ACTION_ADDR = 16'h07F0;
  localparam logic [15:0] FLAG_ADDR   = 16'h07F2;
  localparam logic [15:0] NO_HOP      = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPUTE   = 3'd1,
    WR_ACTION = 3'd2,
    WR_FLAG   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_hop;
  logic [15:0] r_sink;
  logic [15:0] r_action;
  logic        r_for_agg;
  logic [15:0] r_address;
  logic [15:0] r_mem_data_in;
  logic        r_wr_en;
  logic        r_done;
  logic [15:0] w_action;
  logic        w_for_agg;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_action  = r_hop;
    w_for_agg = 1'b0;
    // An invalid hop never goes to aggregation, even if the sink code matches.
    if (r_hop != NO_HOP) w_for_agg = (r_hop == r_sink);
    else                 w_action  = NO_HOP;
    case (r_state)
      IDLE:      if (bus.start) w_next = COMPUTE;
      COMPUTE:   w_next = WR_ACTION;
      WR_ACTION: w_next = WR_FLAG;
      WR_FLAG:   w_next = DONE;
      DONE:      if (!bus.start) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_hop         <= '0;
      r_sink        <= '0;
      r_action      <= '0;
      r_for_agg     <= 1'b0;
      r_address     <= '0;
      r_mem_data_in <= '0;
      r_wr_en       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.en) begin
        r_hop  <= bus.nexthop;
        r_sink <= bus.nextsinks;
      end
      if (r_state == COMPUTE) begin
        r_action  <= w_action;
        r_for_agg <= w_for_agg;
      end
      r_wr_en <= (w_next == WR_ACTION) || (w_next == WR_FLAG);
      r_done  <= (w_next == DONE);
      case (w_next)
        WR_ACTION: begin
          r_address     <= ACTION_ADDR;
          r_mem_data_in <= w_action;
        end
        WR_FLAG: begin
          r_address     <= FLAG_ADDR;
          r_mem_data_in <= {15'b0, r_for_agg};
        end
        default: begin
          r_address     <= '0;
          r_mem_data_in <= '0;
        end
      endcase
    end
  end

  assign bus.address        = r_address;
  assign bus.wr_en          = r_wr_en;
  assign bus.mem_data_in    = r_mem_data_in;
  assign bus.action         = r_action;
  assign bus.forAggregation = r_for_agg;
  assign bus.done           = r_done;

endmodule

// File: tb/tb_select_my_action.sv
// Directed bench for select_my_action: hand-computed results, write sequence,
// done handshake, load lockout and asynchronous reset mid-write.
module tb_select_my_action;

  logic clock;
  logic nrst;
  int   n_tests;
  int   n_fail;
  int   wr_cnt;
  logic [7:0] mem_model [2048];

  select_my_action_if bus ();

  select_my_action u_dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      wr_cnt <= 0;
    end else if (bus.wr_en) begin
      wr_cnt <= wr_cnt + 1;
      mem_model[bus.address[10:0]]         <= bus.mem_data_in[7:0];
      mem_model[bus.address[10:0] + 11'd1] <= bus.mem_data_in[15:8];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [15:0] mem_word(input int a);
    return {mem_model[a + 1], mem_model[a]};
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_wr_en"}, 16'(bus.wr_en), 16'h0);
    chk({tag, "_addr"}, bus.address, 16'h0);
    chk({tag, "_data"}, bus.mem_data_in, 16'h0);
    chk({tag, "_done"}, 16'(bus.done), 16'h0);
  endtask

  // Raises start at a negedge and checks the full run including the done hold.
  task automatic run_sel(input string tag, input logic [15:0] ea, input logic ef);
    int wc0;
    bus.start = 1'b1;
    step();
    chk({tag, "_c_wr_en"}, 16'(bus.wr_en), 16'h0);
    chk({tag, "_c_done"}, 16'(bus.done), 16'h0);
    step();
    chk({tag, "_action"}, bus.action, ea);
    chk({tag, "_fagg"}, 16'(bus.forAggregation), 16'(ef));
    chk({tag, "_wa_wr_en"}, 16'(bus.wr_en), 16'h1);
    chk({tag, "_wa_addr"}, bus.address, 16'h07F0);
    chk({tag, "_wa_data"}, bus.mem_data_in, ea);
    step();
    chk({tag, "_wf_wr_en"}, 16'(bus.wr_en), 16'h1);
    chk({tag, "_wf_addr"}, bus.address, 16'h07F2);
    chk({tag, "_wf_data"}, bus.mem_data_in, 16'(ef));
    step();
    chk({tag, "_d_done"}, 16'(bus.done), 16'h1);
    chk({tag, "_d_wr_en"}, 16'(bus.wr_en), 16'h0);
    chk({tag, "_d_addr"}, bus.address, 16'h0);
    chk({tag, "_mem_act"}, mem_word(16'h07F0), ea);
    chk({tag, "_mem_flag"}, mem_word(16'h07F2), 16'(ef));
    wc0 = wr_cnt;
    repeat (4) step();
    chk({tag, "_hold_done"}, 16'(bus.done), 16'h1);
    chk({tag, "_hold_writes"}, 16'(wr_cnt - wc0), 16'h0);
    chk({tag, "_hold_action"}, bus.action, ea);
    bus.start = 1'b0;
    step();
    chk({tag, "_rel_done"}, 16'(bus.done), 16'h0);
    chk({tag, "_rel_action"}, bus.action, ea);
  endtask

  task automatic load(input logic [15:0] hop, input logic [15:0] sink);
    bus.en        = 1'b1;
    bus.nexthop   = hop;
    bus.nextsinks = sink;
    step();
    bus.en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 2048; i++) mem_model[i] = 8'hAA;
    bus.en        = 1'b0;
    bus.start     = 1'b1;
    bus.nexthop   = 16'h1234;
    bus.nextsinks = 16'h1234;
    nrst          = 1'b0;

    // Reset with start held high: nothing moves.
    repeat (3) step();
    chk_idle_outs("rst");
    chk("rst_action", bus.action, 16'h0);
    chk("rst_fagg", 16'(bus.forAggregation), 16'h0);
    bus.start = 1'b0;
    nrst = 1'b1;
    step();
    chk_idle_outs("post_rst");

    load(16'd65, 16'd65);
    run_sel("agg", 16'h0041, 1'b1);

    load(16'd12, 16'd65);
    run_sel("fwd", 16'd12, 1'b0);

    load(16'hFFFF, 16'hFFFF);
    run_sel("inv", 16'hFFFF, 1'b0);

    // en together with start: new operands are used.
    bus.en        = 1'b1;
    bus.nexthop   = 16'd7;
    bus.nextsinks = 16'd7;
    bus.start     = 1'b1;
    step();
    bus.en = 1'b0;
    step();
    chk("same_edge_action", bus.action, 16'd7);
    chk("same_edge_fagg", 16'(bus.forAggregation), 16'h1);
    repeat (2) step();
    chk("same_edge_done", 16'(bus.done), 16'h1);
    bus.start = 1'b0;
    step();

    // Load lockout: en during WR_ACTION is ignored.
    load(16'd12, 16'd65);
    bus.start = 1'b1;
    repeat (2) step();
    chk("lock_wa_wr_en", 16'(bus.wr_en), 16'h1);
    bus.en        = 1'b1;
    bus.nexthop   = 16'd99;
    bus.nextsinks = 16'd99;
    step();
    bus.en = 1'b0;
    chk("lock_wf_data", bus.mem_data_in, 16'h0);
    step();
    chk("lock_action", bus.action, 16'd12);
    chk("lock_fagg", 16'(bus.forAggregation), 16'h0);
    bus.start = 1'b0;
    step();
    run_sel("lock_rerun", 16'd12, 1'b0);

    // Reset during WR_FLAG.
    load(16'd65, 16'd65);
    bus.start = 1'b1;
    repeat (3) step();
    chk("mid_wf_wr_en", 16'(bus.wr_en), 16'h1);
    chk("mid_wf_addr", bus.address, 16'h07F2);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_wr_en", 16'(bus.wr_en), 16'h0);
    chk("mid_rst_addr", bus.address, 16'h0);
    chk("mid_rst_action", bus.action, 16'h0);
    chk("mid_rst_fagg", 16'(bus.forAggregation), 16'h0);
    repeat (2) step();
    chk("mid_rst_done", 16'(bus.done), 16'h0);
    bus.start = 1'b0;
    nrst = 1'b1;
    step();
    chk_idle_outs("mid_after");
    // Operands were cleared to 0/0, so hop equals sink.
    run_sel("after_rst", 16'h0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
